// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit ALU with a valid/ready handshake and registered outputs.
// Single-cycle ops (AND, OR, ADD, SUB, SLT, NOR) land in DONE one cycle after
// accept. The optional shift-add multiplier is compiled in with the
// ALU_SEQ_MUL_EN macro; without it, opcode 1000 is reported as illegal.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request (in_ready=1, out_valid=0)
// BUSY  | multiply in progress, one shift-add step per cycle
// DONE  | result presented (out_valid=1), waits for out_ready
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             err
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int         CW     = $clog2(WIDTH + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             accept;
    logic             is_mul;
    logic             is_sub;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   add_full;
    logic             c_into_msb;
    logic             add_ovf;

    logic [WIDTH-1:0] res_c;
    logic             cout_c;
    logic             ovf_c;
    logic             err_c;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             cout_q;
    logic             ovf_q;
    logic             err_q;

    assign accept = in_valid && (state_q == ST_IDLE);

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH:0]     mul_part;
    logic [2*WIDTH-1:0] acc_next;

    assign is_mul = (alu_ctrl == OP_MUL);

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the whole accumulator right, retiring one multiplier bit.
    always_comb begin
        mul_part = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_next = {mul_part, acc_q[WIDTH-1:1]};
    end

    assign hi = hi_q;
`else
    assign is_mul = 1'b0;
    assign hi     = '0;
`endif

    // Shared adder: SUB and SLT reuse it as A + ~B + 1.
    always_comb begin
        is_sub     = (alu_ctrl == OP_SUB) || (alu_ctrl == OP_SLT);
        b_x        = is_sub ? ~src2 : src2;
        add_full   = {1'b0, src1} + {1'b0, b_x} + {{WIDTH{1'b0}}, is_sub};
        c_into_msb = src1[WIDTH-1] ^ b_x[WIDTH-1] ^ add_full[WIDTH-1];
        add_ovf    = c_into_msb ^ add_full[WIDTH];
    end

    // Single-cycle result selection; anything unrecognised flags err with a zero result.
    always_comb begin
        res_c  = '0;
        cout_c = 1'b0;
        ovf_c  = 1'b0;
        err_c  = 1'b0;
        case (alu_ctrl)
            OP_AND: res_c = src1 & src2;
            OP_OR:  res_c = src1 | src2;
            OP_NOR: res_c = ~(src1 | src2);
            OP_ADD, OP_SUB: begin
                res_c  = add_full[WIDTH-1:0];
                cout_c = add_full[WIDTH];
                ovf_c  = add_ovf;
            end
            OP_SLT: res_c = {{(WIDTH-1){1'b0}}, add_full[WIDTH-1] ^ add_ovf};
            default: err_c = 1'b1;
        endcase
    end

    // Next-state logic; a DONE cycle never accepts, even with out_ready high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = is_mul ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
`ifdef ALU_SEQ_MUL_EN
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output and multiplier registers; outputs only change when a new result lands.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            hi_q     <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            if (accept && !is_mul) begin
                result_q <= res_c;
                zero_q   <= (res_c == '0);
                cout_q   <= cout_c;
                ovf_q    <= ovf_c;
                err_q    <= err_c;
`ifdef ALU_SEQ_MUL_EN
                hi_q     <= '0;
`endif
            end
`ifdef ALU_SEQ_MUL_EN
            if (accept && is_mul) begin
                mcand_q <= src1;
                acc_q   <= {{WIDTH{1'b0}}, src2};
                cnt_q   <= CW'(WIDTH);
            end
            if (state_q == ST_BUSY) begin
                if (cnt_q != '0) begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    result_q <= acc_q[WIDTH-1:0];
                    hi_q     <= acc_q[2*WIDTH-1:WIDTH];
                    zero_q   <= (acc_q[WIDTH-1:0] == '0);
                    cout_q   <= 1'b0;
                    ovf_q    <= |acc_q[2*WIDTH-1:WIDTH];
                    err_q    <= 1'b0;
                end
            end
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign err       = err_q;

endmodule
